// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for decode-stage interlock.
// Optional SB_FWD_EN: ready-but-unretired writes are treated as forwardable (not busy).
module reg_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int RPORTS = 2,
  parameter int PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 iss_valid,
  input  logic                 iss_fire,
  input  logic                 iss_we,
  input  logic [AW-1:0]        iss_dest,
  input  logic [RPORTS-1:0]    rd_en,
  input  logic [RPORTS*AW-1:0] rd_addr,
  input  logic                 rdy_valid,
  input  logic [AW-1:0]        rdy_dest,
  input  logic                 ret_valid,
  input  logic [AW-1:0]        ret_dest,
  output logic [RPORTS-1:0]    rd_busy,
  output logic                 stall,
  output logic                 err
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] pend_cnt [NREG];
  logic [PEND_W-1:0] pend_nxt [NREG];
  logic [NREG-1:0]   iss_ok, ret_ok, ev_bad, reg_busy, reg_sat;
  logic              err_nxt;

  function automatic logic is_sat(input logic [PEND_W-1:0] cnt);
    return cnt == CNT_MAX;
  endfunction

`ifdef SB_FWD_EN
  logic [PEND_W-1:0] rdy_cnt [NREG];
  logic [PEND_W-1:0] rdy_nxt [NREG];
  logic [NREG-1:0]   rdy_ok;
`else
  logic unused_rdy;
  assign unused_rdy = ^{rdy_valid, rdy_dest};
`endif

  // Next-state counters; illegal events raise err and leave their counter untouched
  always_comb begin
    iss_ok  = '0;
    ret_ok  = '0;
    ev_bad  = '0;
    for (int r = 0; r < NREG; r++) pend_nxt[r] = '0;
`ifdef SB_FWD_EN
    rdy_ok = '0;
    for (int r = 0; r < NREG; r++) rdy_nxt[r] = '0;
`endif
    for (int r = 1; r < NREG; r++) begin
      iss_ok[r] = iss_fire & iss_we & (iss_dest == AW'(r)) & ~is_sat(pend_cnt[r]);
      ret_ok[r] = ret_valid & (ret_dest == AW'(r)) & (pend_cnt[r] != '0);
      ev_bad[r] = (iss_fire & iss_we & (iss_dest == AW'(r)) & is_sat(pend_cnt[r])) |
                  (ret_valid & (ret_dest == AW'(r)) & (pend_cnt[r] == '0));
      pend_nxt[r] = pend_cnt[r] + PEND_W'(iss_ok[r]) - PEND_W'(ret_ok[r]);
`ifdef SB_FWD_EN
      rdy_ok[r] = rdy_valid & (rdy_dest == AW'(r)) & (rdy_cnt[r] != pend_cnt[r]);
      ev_bad[r] = ev_bad[r] | (rdy_valid & (rdy_dest == AW'(r)) & (rdy_cnt[r] == pend_cnt[r]));
      // A retire always consumes one ready slot, including one made ready this cycle
      rdy_nxt[r] = rdy_cnt[r] + PEND_W'(rdy_ok[r])
                 - PEND_W'(ret_ok[r] & ((rdy_cnt[r] != '0) | rdy_ok[r]));
`endif
    end
    err_nxt = |ev_bad;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int r = 0; r < NREG; r++) pend_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) pend_cnt[r] <= pend_nxt[r];
    end
  end

`ifdef SB_FWD_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int r = 0; r < NREG; r++) rdy_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) rdy_cnt[r] <= rdy_nxt[r];
    end
  end
`endif

  // err survives flush; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if (!flush && err_nxt) err <= 1'b1;
  end

  always_comb begin
    reg_busy = '0;
    reg_sat  = '0;
    for (int r = 1; r < NREG; r++) begin
`ifdef SB_FWD_EN
      reg_busy[r] = pend_cnt[r] != rdy_cnt[r];
`else
      reg_busy[r] = pend_cnt[r] != '0;
`endif
      reg_sat[r] = is_sat(pend_cnt[r]);
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < RPORTS; i++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_en[i] && rd_addr[i*AW +: AW] == AW'(r)) rd_busy[i] = reg_busy[r];
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (iss_we && iss_dest == AW'(r) && reg_sat[r]) stall = 1'b1;
    end
    stall = iss_valid & (stall | (|rd_busy));
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard; expected outputs queued per driven cycle.
module tb_reg_scoreboard;

  logic       clk, reset, flush, iss_valid, iss_fire, iss_we;
  logic [4:0] iss_dest, rdy_dest, ret_dest;
  logic [1:0] rd_en;
  logic [9:0] rd_addr;
  logic       rdy_valid, ret_valid;
  logic [1:0] rd_busy;
  logic       stall, err;

  reg_scoreboard #(.NREG(32), .AW(5), .RPORTS(2), .PEND_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .iss_valid(iss_valid), .iss_fire(iss_fire), .iss_we(iss_we), .iss_dest(iss_dest),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rdy_valid(rdy_valid), .rdy_dest(rdy_dest),
    .ret_valid(ret_valid), .ret_dest(ret_dest),
    .rd_busy(rd_busy), .stall(stall), .err(err)
  );

  typedef struct {
    logic rst, fl, iv, ifr, iwe; logic [4:0] idest;
    logic [1:0] rden; logic [4:0] ra1, ra0;
    logic rdyv; logic [4:0] rdyd; logic retv; logic [4:0] retd;
    logic [1:0] eb; logic es, ee;
  } vec_t;

  typedef struct { logic [1:0] b; logic s, e; int id; } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int step_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, got no finish, want finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic ifr, logic iwe, logic [4:0] idest,
                              logic [1:0] rden, logic [4:0] ra1, logic [4:0] ra0,
                              logic rdyv, logic [4:0] rdyd, logic retv, logic [4:0] retd,
                              logic [1:0] eb, logic es, logic ee);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ifr = ifr; v.iwe = iwe; v.idest = idest;
    v.rden = rden; v.ra1 = ra1; v.ra0 = ra0; v.rdyv = rdyv; v.rdyd = rdyd;
    v.retv = retv; v.retd = retd; v.eb = eb; v.es = es; v.ee = ee;
    return v;
  endfunction

  task automatic check1(string nm, int id, logic [1:0] act, logic [1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %b want %b", nm, id, act, want);
    end
  endtask

  task automatic step(vec_t v);
    exp_t x;
    reset = v.rst; flush = v.fl; iss_valid = v.iv; iss_fire = v.ifr; iss_we = v.iwe;
    iss_dest = v.idest; rd_en = v.rden; rd_addr = {v.ra1, v.ra0};
    rdy_valid = v.rdyv; rdy_dest = v.rdyd; ret_valid = v.retv; ret_dest = v.retd;
    x.b = v.eb; x.s = v.es; x.e = v.ee; x.id = step_id;
    exp_q.push_back(x);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard step %0d: got empty queue want one entry", step_id);
    end else begin
      x = exp_q.pop_front();
      check1("rd_busy", x.id, rd_busy, x.b);
      check1("stall", x.id, {1'b0, stall}, {1'b0, x.s});
      check1("err", x.id, {1'b0, err}, {1'b0, x.e});
    end
    step_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] fb;
    logic       fs, fe;
`ifdef SB_FWD_EN
    fb = 2'b00; fs = 1'b0; fe = 1'b1;
`else
    fb = 2'b01; fs = 1'b1; fe = 1'b0;
`endif
    reset = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_fire = 1'b0; iss_we = 1'b0;
    iss_dest = '0; rd_en = '0; rd_addr = '0; rdy_valid = 1'b0; rdy_dest = '0;
    ret_valid = 1'b0; ret_dest = '0;
    @(posedge clk);
    #1;

    // rst fl iv ifr iwe idest rden ra1 ra0 rdyv rdyd retv retd | eb es ee
    tbl.push_back(mk(1,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));  // reset state
    tbl.push_back(mk(0,0,1,1,1, 5, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));  // issue r5
    tbl.push_back(mk(0,0,1,0,0, 0, 2'b01, 0, 5, 0,0, 0,0, 2'b01,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0, 5, 0,0, 1,5, 2'b01,0,0));  // retire r5
    tbl.push_back(mk(0,0,1,0,0, 0, 2'b01, 0, 5, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,1,1,1, 0, 2'b11, 0, 0, 0,0, 0,0, 2'b00,0,0));  // issue r0
    tbl.push_back(mk(0,0,1,0,0, 0, 2'b11, 0, 0, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,1,1,1, 7, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));  // r7 x3
    tbl.push_back(mk(0,0,1,1,1, 7, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,1,1,1, 7, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,1,0,1, 7, 2'b00, 0, 0, 0,0, 0,0, 2'b00,1,0));  // saturated
    tbl.push_back(mk(0,0,1,0,1, 7, 2'b00, 0, 0, 0,0, 1,7, 2'b00,1,0));
    tbl.push_back(mk(0,0,1,0,1, 7, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b10, 7, 0, 0,0, 0,0, 2'b10,0,0));  // port 1
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 1,7, 2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 1,7, 2'b00,0,0));
    tbl.push_back(mk(0,0,1,1,1, 9, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));  // r9
    tbl.push_back(mk(0,0,1,1,1, 9, 2'b00, 0, 0, 0,0, 1,9, 2'b00,0,0));  // issue+retire
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0, 9, 0,0, 0,0, 2'b01,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0, 9, 0,0, 1,9, 2'b01,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0, 9, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,1,1,1, 4, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));  // r4 ready
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0, 4, 1,4, 0,0, 2'b01,0,0));
    tbl.push_back(mk(0,0,1,0,0, 0, 2'b01, 0, 4, 0,0, 0,0, fb,   fs,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0, 4, 0,0, 1,4, fb,   0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0, 4, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,1,1,1, 3, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));  // r3 r8 r12
    tbl.push_back(mk(0,0,1,1,1, 8, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,1,1,1,12, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b11, 8, 3, 0,0, 0,0, 2'b11,0,0));
    tbl.push_back(mk(0,1,1,1,1, 3, 2'b11, 3,12, 0,0, 0,0, 2'b11,1,0));  // flush+issue
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b11, 8,12, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0, 3, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 1,3, 2'b00,0,0));  // bad retire
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,1));
    tbl.push_back(mk(0,1,0,0,0, 0, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,1));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,1));
    tbl.push_back(mk(0,0,1,1,1,10, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,1));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0,10, 0,0, 0,0, 2'b01,0,1));
    tbl.push_back(mk(1,0,0,0,0, 0, 2'b01, 0,10, 0,0, 0,0, 2'b01,0,1));  // mid reset
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b01, 0,10, 0,0, 0,0, 2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b00, 0, 0, 1,20, 0,0, 2'b00,0,0)); // ready, none pending
    tbl.push_back(mk(0,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,fe));
    tbl.push_back(mk(1,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,fe));

    foreach (tbl[k]) step(tbl[k]);

    // Issue into a saturated counter: err sets and the counter must not wrap
    for (int k = 0; k < 3; k++) step(mk(0,0,1,1,1, 7, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));
    step(mk(0,0,1,1,1, 7, 2'b00, 0, 0, 0,0, 0,0, 2'b00,1,0));
    step(mk(0,0,0,0,0, 0, 2'b01, 0, 7, 0,0, 0,0, 2'b01,0,1));
    step(mk(0,0,0,0,0, 0, 2'b01, 0, 7, 0,0, 1,7, 2'b01,0,1));
    step(mk(0,0,0,0,0, 0, 2'b01, 0, 7, 0,0, 1,7, 2'b01,0,1));
    step(mk(0,0,0,0,0, 0, 2'b01, 0, 7, 0,0, 1,7, 2'b01,0,1));
    step(mk(0,0,0,0,0, 0, 2'b01, 0, 7, 0,0, 0,0, 2'b00,0,1));
    step(mk(1,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,1));
    step(mk(0,0,0,0,0, 0, 2'b00, 0, 0, 0,0, 0,0, 2'b00,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
